// File: rtl/poly_term_eval_pkg.sv
// Shared widths and types for the iterative sum-of-monomials evaluator.
// Optional overflow flag output is enabled by defining POLY_OVF_FLAG_EN.
package poly_pkg;

  localparam int W_IN  = 8;
  localparam int W_OUT = 24;
  localparam int W_EXP = 3;

  localparam logic [W_EXP-1:0] EXP_ONE = W_EXP'(1);

  typedef enum logic [2:0] {
    IDLE,
    WAIT,
    MUL,
    ACC,
    DONE
  } state_t;

  typedef struct packed {
    logic [W_OUT-1:0] coef;
    logic [W_EXP-1:0] e1;
    logic [W_EXP-1:0] e2;
    logic [W_EXP-1:0] e3;
    logic             last;
  } term_t;

endpackage

// File: rtl/poly_term_eval_if.sv
// Term-stream / result bus of poly_term_eval; master drives terms, slave is the evaluator.
// res_ovf exists only when POLY_OVF_FLAG_EN is defined.
interface poly_term_eval_if;
  import poly_pkg::*;

  logic [W_IN-1:0]  in1;
  logic [W_IN-1:0]  in2;
  logic [W_IN-1:0]  in3;
  logic             term_valid;
  logic             term_ready;
  logic [W_OUT-1:0] term_coef;
  logic [W_EXP-1:0] term_e1;
  logic [W_EXP-1:0] term_e2;
  logic [W_EXP-1:0] term_e3;
  logic             term_last;
  logic             res_valid;
  logic             res_ready;
  logic [W_OUT-1:0] res_data;
  logic             busy;
`ifdef POLY_OVF_FLAG_EN
  logic             res_ovf;
`endif

  modport master (
    output in1, in2, in3, term_valid, term_coef, term_e1, term_e2, term_e3, term_last,
    output res_ready,
    input  term_ready, res_valid, res_data, busy
`ifdef POLY_OVF_FLAG_EN
    , input res_ovf
`endif
  );

  modport slave (
    input  in1, in2, in3, term_valid, term_coef, term_e1, term_e2, term_e3, term_last,
    input  res_ready,
    output term_ready, res_valid, res_data, busy
`ifdef POLY_OVF_FLAG_EN
    , output res_ovf
`endif
  );

endinterface

// File: rtl/poly_term_eval_mono_mul.sv
// Iterative monomial multiplier: loads coef on start, then one multiply per cycle
// (in1 first, then in2, then in3) until all exponents are spent. POLY_OVF_FLAG_EN adds ovf_o.
module poly_mono_mul
  import poly_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [W_OUT-1:0] coef_i,
  input  logic [W_EXP-1:0] e1_i,
  input  logic [W_EXP-1:0] e2_i,
  input  logic [W_EXP-1:0] e3_i,
  input  logic [W_IN-1:0]  op1_i,
  input  logic [W_IN-1:0]  op2_i,
  input  logic [W_IN-1:0]  op3_i,
  output logic             last_step_o,
  output logic [W_OUT-1:0] prod_o
`ifdef POLY_OVF_FLAG_EN
  , output logic           ovf_o
`endif
);

  logic [W_OUT-1:0] prod_q, prod_d, prod_step;
  logic [W_EXP-1:0] e1_q, e1_d, e2_q, e2_d, e3_q, e3_d;
  logic [W_IN-1:0]  op;
  logic [W_EXP+1:0] remaining;
  logic             stepping;

  assign remaining   = {2'b00, e1_q} + {2'b00, e2_q} + {2'b00, e3_q};
  assign stepping    = (remaining != '0);
  assign last_step_o = (remaining == (W_EXP+2)'(1));
  assign prod_o      = prod_q;

`ifdef POLY_OVF_FLAG_EN
  logic [W_OUT+W_IN-1:0] full;
  assign full      = {{W_IN{1'b0}}, prod_q} * {{W_OUT{1'b0}}, op};
  assign prod_step = full[W_OUT-1:0];
  assign ovf_o     = stepping && (full[W_OUT+W_IN-1:W_OUT] != '0);
`else
  assign prod_step = prod_q * {{(W_OUT-W_IN){1'b0}}, op};
`endif

  always_comb begin
    op     = op3_i;
    e1_d   = e1_q;
    e2_d   = e2_q;
    e3_d   = e3_q;
    prod_d = prod_q;
    if (e1_q != '0) begin
      op   = op1_i;
      e1_d = e1_q - EXP_ONE;
    end else if (e2_q != '0) begin
      op   = op2_i;
      e2_d = e2_q - EXP_ONE;
    end else if (e3_q != '0) begin
      e3_d = e3_q - EXP_ONE;
    end
    if (stepping) prod_d = prod_step;
    // A zero coefficient zeroes the exponents so no multiply cycles are spent on it
    if (start_i) begin
      prod_d = coef_i;
      e1_d   = (coef_i != '0) ? e1_i : '0;
      e2_d   = (coef_i != '0) ? e2_i : '0;
      e3_d   = (coef_i != '0) ? e3_i : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prod_q <= '0;
      e1_q   <= '0;
      e2_q   <= '0;
      e3_q   <= '0;
    end else begin
      prod_q <= prod_d;
      e1_q   <= e1_d;
      e2_q   <= e2_d;
      e3_q   <= e3_d;
    end
  end

endmodule

// File: rtl/poly_term_eval.sv
// Frame sequencer: res = sum(coef*in1^e1*in2^e2*in3^e3) mod 2^W_OUT over a term stream.
// POLY_OVF_FLAG_EN adds res_ovf (any discarded high bits in the frame).
//   state | meaning
//   IDLE  | no frame; first term latches operands and clears acc
//   WAIT  | mid-frame, waiting for next term
//   MUL   | monomial multiplier stepping
//   ACC   | acc += product
//   DONE  | result held until res_ready
module poly_term_eval
  import poly_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  poly_term_eval_if.slave  bus
);

  state_t           state_q, state_d;
  logic [W_IN-1:0]  in1_q, in1_d, in2_q, in2_d, in3_q, in3_d;
  logic [W_OUT-1:0] acc_q, acc_d, prod, acc_sum;
  logic             last_q, last_d;
  logic             ready, hs, skip, mul_last;
  term_t            term;

  assign term = '{coef: bus.term_coef, e1: bus.term_e1, e2: bus.term_e2,
                  e3: bus.term_e3, last: bus.term_last};

  assign ready = !rst && (state_q == IDLE || state_q == WAIT);
  assign hs    = bus.term_valid && ready;
  assign skip  = (term.coef == '0) || ((term.e1 | term.e2 | term.e3) == '0);

`ifdef POLY_OVF_FLAG_EN
  logic             mul_ovf, acc_carry, ovf_q, ovf_d;
  logic [W_OUT:0]   acc_full;
  assign acc_full  = {1'b0, acc_q} + {1'b0, prod};
  assign acc_sum   = acc_full[W_OUT-1:0];
  assign acc_carry = acc_full[W_OUT];

  always_comb begin
    ovf_d = ovf_q;
    if (state_q == MUL && mul_ovf) ovf_d = 1'b1;
    if (state_q == ACC && acc_carry) ovf_d = 1'b1;
    if (state_q == IDLE && hs) ovf_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) ovf_q <= 1'b0;
    else     ovf_q <= ovf_d;
  end

  assign bus.res_ovf = ovf_q;
`else
  assign acc_sum = acc_q + prod;
`endif

  poly_mono_mul u_mul (
    .clk        (clk),
    .rst        (rst),
    .start_i    (hs),
    .coef_i     (term.coef),
    .e1_i       (term.e1),
    .e2_i       (term.e2),
    .e3_i       (term.e3),
    .op1_i      (in1_q),
    .op2_i      (in2_q),
    .op3_i      (in3_q),
    .last_step_o(mul_last),
    .prod_o     (prod)
`ifdef POLY_OVF_FLAG_EN
    , .ovf_o    (mul_ovf)
`endif
  );

  always_comb begin
    state_d = state_q;
    in1_d   = in1_q;
    in2_d   = in2_q;
    in3_d   = in3_q;
    last_d  = last_q;
    acc_d   = acc_q;
    case (state_q)
      IDLE: if (hs) begin
        in1_d   = bus.in1;
        in2_d   = bus.in2;
        in3_d   = bus.in3;
        acc_d   = '0;
        last_d  = term.last;
        state_d = skip ? ACC : MUL;
      end
      WAIT: if (hs) begin
        last_d  = term.last;
        state_d = skip ? ACC : MUL;
      end
      MUL:  if (mul_last) state_d = ACC;
      ACC: begin
        acc_d   = acc_sum;
        state_d = last_q ? DONE : WAIT;
      end
      DONE: if (bus.res_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      in1_q   <= '0;
      in2_q   <= '0;
      in3_q   <= '0;
      last_q  <= 1'b0;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      in1_q   <= in1_d;
      in2_q   <= in2_d;
      in3_q   <= in3_d;
      last_q  <= last_d;
      acc_q   <= acc_d;
    end
  end

  assign bus.term_ready = ready;
  assign bus.res_valid  = (state_q == DONE);
  assign bus.res_data   = acc_q;
  assign bus.busy       = (state_q != IDLE);

endmodule

// File: tb/tb_poly_term_eval.sv
// Directed, table-driven bench for poly_term_eval with hand-computed results and term timing.
module tb_poly_term_eval;
  import poly_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  poly_term_eval_if bus();

  poly_term_eval dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    bit          first;
    logic [7:0]  a, b, c;
    logic [23:0] coef;
    logic [2:0]  e1, e2, e3;
    bit          last;
    int          occ;
    logic [31:0] res;
    bit          ovf;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge just after the handshake edge.
  task automatic accept_term(input logic [23:0] coef, input logic [2:0] e1, e2, e3,
                             input bit last);
    int n;
    bus.term_coef  = coef;
    bus.term_e1    = e1;
    bus.term_e2    = e2;
    bus.term_e3    = e3;
    bus.term_last  = last;
    bus.term_valid = 1'b1;
    n = 0;
    while (!bus.term_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!bus.term_ready) begin
      n_chk++;
      n_fail++;
      $display("FAIL accept_timeout: term_ready never rose within %0d cycles", n);
    end
    @(negedge clk);
    bus.term_valid = 1'b0;
  endtask

  task automatic send_term(input logic [23:0] coef, input logic [2:0] e1, e2, e3,
                           input bit last, output int occ);
    accept_term(coef, e1, e2, e3, last);
    occ = 1;
    while (!(bus.term_ready || bus.res_valid) && occ < 50) begin
      occ++;
      @(negedge clk);
    end
  endtask

  task automatic take_result();
    bus.res_ready = 1'b1;
    @(negedge clk);
    bus.res_ready = 1'b0;
    check("res_valid_after_take", 32'(bus.res_valid), 0);
    check("busy_after_take", 32'(bus.busy), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int occ;
    vecs[0] = '{1, 3, 0, 5,   24'd8388608, 1, 0, 0, 0, 3, 0,            0};
    vecs[1] = '{0, 0, 0, 0,   24'd1,       3, 0, 0, 1, 5, 32'h80001B,   1};
    vecs[2] = '{1, 255, 0, 0, 24'd1,       4, 0, 0, 1, 6, 32'h05FC01,   1};
    vecs[3] = '{1, 7, 0, 9,   24'd5,       0, 0, 0, 0, 2, 0,            0};
    vecs[4] = '{0, 0, 0, 0,   24'd3,       0, 2, 0, 0, 4, 0,            0};
    vecs[5] = '{0, 0, 0, 0,   24'd0,       7, 7, 7, 1, 2, 5,            0};
    vecs[6] = '{1, 2, 3, 4,   24'd1,       1, 1, 1, 0, 5, 0,            0};
    vecs[7] = '{0, 0, 0, 0,   24'hFFFFFF,  0, 0, 0, 1, 2, 23,           1};
    vecs[8] = '{1, 2, 3, 4,   24'd5,       2, 1, 1, 1, 6, 240,          0};

    rst = 1'b1;
    bus.in1 = '0; bus.in2 = '0; bus.in3 = '0;
    bus.term_valid = 1'b0; bus.term_coef = '0;
    bus.term_e1 = '0; bus.term_e2 = '0; bus.term_e3 = '0; bus.term_last = 1'b0;
    bus.res_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_res_valid", 32'(bus.res_valid), 0);
    check("rst_busy", 32'(bus.busy), 0);
    check("rst_res_data", 32'(bus.res_data), 0);
    check("rst_term_ready", 32'(bus.term_ready), 0);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_term_ready", 32'(bus.term_ready), 1);

    for (int i = 0; i < 9; i++) begin
      if (vecs[i].first) begin
        bus.in1 = vecs[i].a;
        bus.in2 = vecs[i].b;
        bus.in3 = vecs[i].c;
      end else begin
        bus.in1 = 8'($urandom);
        bus.in2 = 8'($urandom);
        bus.in3 = 8'($urandom);
      end
      send_term(vecs[i].coef, vecs[i].e1, vecs[i].e2, vecs[i].e3, vecs[i].last, occ);
      check($sformatf("occ[%0d]", i), 32'(occ), 32'(vecs[i].occ));
      if (vecs[i].last) begin
        check($sformatf("res_valid[%0d]", i), 32'(bus.res_valid), 1);
        check($sformatf("res_data[%0d]", i), 32'(bus.res_data), vecs[i].res);
        check($sformatf("busy_done[%0d]", i), 32'(bus.busy), 1);
        check($sformatf("ready_done[%0d]", i), 32'(bus.term_ready), 0);
`ifdef POLY_OVF_FLAG_EN
        check($sformatf("res_ovf[%0d]", i), 32'(bus.res_ovf), 32'(vecs[i].ovf));
`endif
        take_result();
      end else begin
        check($sformatf("busy_wait[%0d]", i), 32'(bus.busy), 1);
      end
    end

    // Backpressure: result held, pending term waits, operands re-sampled afterwards
    bus.in1 = 8'd2; bus.in2 = 8'd0; bus.in3 = 8'd0;
    send_term(24'd7, 3'd1, 3'd0, 3'd0, 1'b1, occ);
    check("bp_occ", 32'(occ), 3);
    bus.in1 = 8'd5;
    bus.term_coef = 24'd1; bus.term_e1 = 3'd1; bus.term_e2 = 3'd0; bus.term_e3 = 3'd0;
    bus.term_last = 1'b1;
    bus.term_valid = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check("bp_res_valid", 32'(bus.res_valid), 1);
      check("bp_res_data", 32'(bus.res_data), 14);
      check("bp_term_ready", 32'(bus.term_ready), 0);
    end
    bus.res_ready = 1'b1;
    @(negedge clk);
    bus.res_ready = 1'b0;
    send_term(24'd1, 3'd1, 3'd0, 3'd0, 1'b1, occ);
    check("bp_next_occ", 32'(occ), 3);
    check("bp_next_res", 32'(bus.res_data), 5);
    take_result();

    // Reset during a long multiply discards the frame
    bus.in1 = 8'd3;
    accept_term(24'd1, 3'd6, 3'd0, 3'd0, 1'b1);
    @(negedge clk);
    check("mid_busy", 32'(bus.busy), 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    begin
      int seen;
      seen = 0;
      for (int k = 0; k < 10; k++) begin
        @(negedge clk);
        if (bus.res_valid) seen++;
      end
      check("mid_rst_no_res", 32'(seen), 0);
    end
    check("mid_rst_busy", 32'(bus.busy), 0);
    bus.in1 = 8'd4;
    send_term(24'd2, 3'd1, 3'd0, 3'd0, 1'b1, occ);
    check("after_rst_occ", 32'(occ), 3);
    check("after_rst_res", 32'(bus.res_data), 8);
`ifdef POLY_OVF_FLAG_EN
    check("after_rst_ovf", 32'(bus.res_ovf), 0);
`endif
    take_result();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
